// File: rtl/systolic_feeder.sv
// systolic_feeder: reads ROWS FIFOs on a diagonally skewed schedule and feeds signed elements to systolic array rows
module systolic_feeder #(
  parameter int ROWS = 4,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LEN_W-1:0]           len,
  input  logic [ROWS-1:0]            fifo_empty,
  input  logic [ROWS*DATA_WIDTH-1:0] fifo_data,
  output logic [ROWS-1:0]            fifo_r_en,
  output logic [ROWS*DATA_WIDTH-1:0] row_data,
  output logic [ROWS-1:0]            row_valid,
  output logic                       busy,
  output logic                       done
);
  localparam int TW = LEN_W + $clog2(ROWS) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] t, t_n;
  logic [LEN_W-1:0] len_q;
  logic [ROWS-1:0] sched, v1;
  logic stall, last;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign last = t == TW'(len_q) + TW'(ROWS) - TW'(2);
  assign stall = |(sched & fifo_empty);
  assign fifo_r_en = sched & {ROWS{~stall}};
  // diagonal schedule: row i is active for len steps starting at step i
  always_comb begin
    sched = '0;
    for (int i = 0; i < ROWS; i++)
      sched[i] = state == RUN && t >= TW'(i) && t < TW'(i) + TW'(len_q);
  end
  // next state and step counter; t doubles as the flush cycle counter
  always_comb begin
    state_n = state;
    t_n = t;
    case (state)
      IDLE: if (start) begin
        t_n = '0;
        state_n = len == '0 ? DONE : RUN;
      end
      RUN: if (!stall) begin
        t_n = last ? '0 : t + TW'(1);
        state_n = last ? FLUSH : RUN;
      end
      FLUSH: begin
        t_n = t + TW'(1);
        state_n = t == TW'(1) ? DONE : FLUSH;
      end
      DONE: begin
        t_n = '0;
        state_n = IDLE;
      end
    endcase
  end
  // state register, step counter and latched pass length
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      t <= '0;
      len_q <= '0;
    end else begin
      state <= state_n;
      t <= t_n;
      if (state == IDLE && start) len_q <= len;
    end
  // two-stage output pipeline matching the FIFO read latency; keeps advancing through stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1 <= '0;
      row_valid <= '0;
      row_data <= '0;
    end else begin
      v1 <= fifo_r_en;
      row_valid <= v1;
      for (int i = 0; i < ROWS; i++)
        row_data[i*DATA_WIDTH +: DATA_WIDTH] <= v1[i] ? fifo_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed passes with FIFO models and a per-row data scoreboard
module tb_systolic_feeder;
  localparam int ROWS = 4, DW = 16, LW = 8;
  logic clk = 0, rst = 1, start = 0;
  logic [LW-1:0] len = '0;
  logic [ROWS-1:0] fifo_empty, fifo_r_en, row_valid, force_empty = '0, q_empty = '1;
  logic [ROWS*DW-1:0] fifo_data = '0, row_data;
  logic busy, done;
  logic [DW-1:0] fq[ROWS][$];
  logic [DW-1:0] eq[ROWS][$];
  int passed = 0, total = 0;

  systolic_feeder #(.ROWS(ROWS), .DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_r_en(fifo_r_en), .row_data(row_data),
    .row_valid(row_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign fifo_empty = q_empty | force_empty;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // FIFO models: registered read data one cycle after read enable
  always @(posedge clk)
    for (int i = 0; i < ROWS; i++)
      if (fifo_r_en[i] && fq[i].size() > 0) fifo_data[i*DW +: DW] <= fq[i].pop_front();

  // scoreboard: every valid beat pops the row's expected element; idle beats must carry 0
  always @(negedge clk) begin
    for (int i = 0; i < ROWS; i++) q_empty[i] = fq[i].size() == 0;
    if (!rst)
      for (int i = 0; i < ROWS; i++)
        if (row_valid[i]) begin
          if (eq[i].size() == 0) chk($sformatf("row%0d_underflow", i), 1, 0);
          else chk($sformatf("row%0d_data", i), row_data[i*DW +: DW], eq[i].pop_front());
        end else chk($sformatf("row%0d_idle_zero", i), row_data[i*DW +: DW], 0);
  end

  function automatic logic [ROWS-1:0] en_exp(int c, int l, int sf, int sn);
    int tt;
    en_exp = '0;
    if (c < 0 || (c >= sf && c < sf + sn)) return en_exp;
    tt = (sn > 0 && c >= sf + sn) ? c - sn : c;
    for (int i = 0; i < ROWS; i++) en_exp[i] = tt >= i && tt < i + l;
  endfunction

  task automatic preload(input int l);
    logic [DW-1:0] special[3];
    logic [DW-1:0] v;
    special[0] = 16'hFFFB;
    special[1] = 16'h7FFF;
    special[2] = 16'h8000;
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < l; k++) begin
        v = (i == 1 && k < 3) ? special[k] : DW'($urandom);
        fq[i].push_back(v);
        eq[i].push_back(v);
      end
  endtask

  task automatic drained();
    for (int i = 0; i < ROWS; i++) chk($sformatf("row%0d_drained", i), eq[i].size(), 0);
  endtask

  // one pass: stall window [sf, sf+sn) on row 2, optional ignored start pulses, optional reset at cycle rst_at
  task automatic run_pass(input int l, input int sf, input int sn, input int spulse, input int rst_at);
    int last;
    last = (l == 0) ? 0 : l + ROWS + 1 + sn;
    @(negedge clk);
    start = 1;
    len = LW'(l);
    @(negedge clk);
    start = 0;
    for (int c = 0; c <= last + 2; c++) begin
      force_empty = (c >= sf && c < sf + sn) ? 4'b0100 : 4'b0000;
      start = spulse >= 0 && (c == spulse || c == last);
      #1;
      chk($sformatf("fifo_r_en_c%0d", c), fifo_r_en, en_exp(c, l, sf, sn));
      chk($sformatf("row_valid_c%0d", c), row_valid, en_exp(c - 2, l, sf, sn));
      chk($sformatf("busy_c%0d", c), busy, c <= last);
      chk($sformatf("done_c%0d", c), done, c == last);
      if (c == rst_at) begin
        rst = 1;
        #1;
        chk("rst_fifo_r_en", fifo_r_en, 0);
        chk("rst_row_valid", row_valid, 0);
        chk("rst_row_data", row_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        for (int i = 0; i < ROWS; i++) begin
          fq[i].delete();
          eq[i].delete();
        end
        start = 0;
        force_empty = '0;
        repeat (2) begin
          @(negedge clk);
          chk("rst_hold_done", done, 0);
          chk("rst_hold_busy", busy, 0);
        end
        rst = 0;
        return;
      end
      @(negedge clk);
    end
    start = 0;
    force_empty = '0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_fifo_r_en", fifo_r_en, 0);
    chk("reset_row_valid", row_valid, 0);
    chk("reset_row_data", row_data, 0);
    rst = 0;
    preload(3);
    run_pass(3, 0, 0, -1, -1);
    drained();
    preload(3);
    run_pass(3, 2, 3, -1, -1);
    drained();
    preload(3);
    run_pass(3, 0, 0, 4, -1);
    drained();
    run_pass(0, 0, 0, -1, -1);
    preload(3);
    run_pass(3, 0, 0, -1, 3);
    preload(3);
    run_pass(3, 0, 0, -1, -1);
    drained();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
